// File: rtl/irq_multi_pkg.sv
// Shared types for the multi-channel interrupt handler: FSM states and
// the USCITE status encoding.
package irq_multi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_SERVE = 3'd2,
    S_ACK   = 3'd3,
    S_TMO   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam logic [1:0] US_IDLE = 2'b00;
  localparam logic [1:0] US_SERV = 2'b01;
  localparam logic [1:0] US_ACK  = 2'b10;
  localparam logic [1:0] US_ERR  = 2'b11;

endpackage

// File: rtl/irq_rr_pick.sv
// Combinational channel picker. The request vector is laid out twice; the
// lower copy is masked to channels strictly above 'last' (round-robin) or
// fully masked (fixed priority), so the lowest set bit of the doubled
// vector is the winner in either mode, wrapping naturally into the upper copy.
module irq_rr_pick
  import irq_multi_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic             rr_mode,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  localparam int PW = SEL_W + 1;

  logic [N_CH-1:0]   w_mask;
  logic [2*N_CH-1:0] w_dbl;
  logic [PW-1:0]     w_pos;

  assign valid = |req;

  // mask off channels at or below the previous grant when rotating
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_CH; i++)
      w_mask[i] = rr_mode && (i > int'(last));
  end

  assign w_dbl = {req, req & w_mask};

  // lowest set bit of the doubled vector, folded back to a channel index
  always_comb begin
    w_pos = '0;
    for (int i = 2*N_CH-1; i >= 0; i--)
      if (w_dbl[i]) w_pos = PW'(i);
    if (w_pos >= PW'(N_CH)) idx = SEL_W'(w_pos - PW'(N_CH));
    else                    idx = w_pos[SEL_W-1:0];
  end

endmodule

// File: rtl/irq_multi_handler.sv
// Multi-channel interrupt handler: arbitrates level requests, drives the
// external service counter, acknowledges on CONT_EQL, and aborts on a
// dropped request or a per-service timeout. All outputs are registered
// from the next state so they line up with the state they describe.
module irq_multi_handler
  import irq_multi_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int SEL_W   = $clog2(N_CH),
  parameter bit RR_MODE = 1'b0,
  parameter int TMO_CYC = 16,
  parameter int TMO_W   = $clog2(TMO_CYC + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [N_CH-1:0]  REQ,
  input  logic             CONT_EQL,
  input  logic             CLR_ERR,
  output logic [SEL_W-1:0] CC_MUX,
  output logic [1:0]       USCITE,
  output logic             ENABLE_COUNT,
  output logic             ACKOUT,
  output logic             ERR_FLAG
);

  state_t            r_state, w_nxt;
  logic [SEL_W-1:0]  r_cc, r_last, w_pick;
  logic              w_pick_vld, w_req_cur, w_tmo_hit;
  logic [1:0]        r_us;
  logic              r_en, r_ack, r_err;
  logic [TMO_W-1:0]  r_tmo;

  irq_rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req     (REQ),
    .last    (r_last),
    .rr_mode (RR_MODE),
    .idx     (w_pick),
    .valid   (w_pick_vld)
  );

  assign w_req_cur = REQ[r_cc];
  assign w_tmo_hit = (r_tmo == TMO_W'(TMO_CYC - 1));

  // state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // next-state: abort beats ack, ack beats timeout
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|REQ) w_nxt = S_ARB;
      S_ARB:   w_nxt = w_pick_vld ? S_SERVE : S_IDLE;
      S_SERVE: begin
        if (!w_req_cur)     w_nxt = S_IDLE;
        else if (CONT_EQL)  w_nxt = S_ACK;
        else if (w_tmo_hit) w_nxt = S_TMO;
      end
      S_ACK:   w_nxt = S_DRAIN;
      S_TMO:   w_nxt = S_DRAIN;
      S_DRAIN: if (!w_req_cur) w_nxt = (|REQ) ? S_ARB : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // registered outputs, grant bookkeeping and the service watchdog
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cc   <= '0;
      r_last <= SEL_W'(N_CH - 1);
      r_us   <= US_IDLE;
      r_en   <= 1'b0;
      r_ack  <= 1'b0;
      r_tmo  <= '0;
    end else begin
      r_en  <= (w_nxt == S_SERVE);
      r_ack <= (w_nxt == S_ACK);
      if (r_state == S_ARB) r_cc <= w_pick;
      // both completion and timeout demote the served channel
      if (w_nxt == S_ACK || w_nxt == S_TMO) r_last <= r_cc;
      case (w_nxt)
        S_IDLE, S_ARB: r_us <= US_IDLE;
        S_SERVE:       r_us <= US_SERV;
        S_ACK:         r_us <= US_ACK;
        S_TMO:         r_us <= US_ERR;
        default:       r_us <= r_us;   // DRAIN keeps the outcome visible
      endcase
      if (r_state == S_ARB)
        r_tmo <= '0;
      else if (r_state == S_SERVE && r_tmo < TMO_W'(TMO_CYC))
        r_tmo <= r_tmo + 1'b1;
    end
  end

  // sticky timeout flag; a set in the same cycle as a clear wins
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      r_err <= 1'b0;
    else if (r_state == S_SERVE && w_nxt == S_TMO)
      r_err <= 1'b1;
    else if (CLR_ERR)
      r_err <= 1'b0;
  end

  assign CC_MUX       = r_cc;
  assign USCITE       = r_us;
  assign ENABLE_COUNT = r_en;
  assign ACKOUT       = r_ack;
  assign ERR_FLAG     = r_err;

endmodule

// File: doc/irq_multi_handler.md
Name: irq_multi_handler

Overview:
- Parametrised, registered successor to the single-channel interrupt controller FSM (ITC99 b06 class).
- Arbitrates N_CH level-sensitive interrupt requests, in fixed-priority or round-robin mode.
- Drives the external service counter through ENABLE_COUNT and waits for CONT_EQL. Acknowledges with ACKOUT.
- Adds a per-service timeout watchdog and spurious-request abort, which the single-channel block lacks.

Parameters:
- N_CH, 4, number of request channels (2..16).
- SEL_W, $clog2(N_CH), width of the channel index.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TMO_CYC, 16, max cycles in SERVE without CONT_EQL before timeout (≥2).
- TMO_W, $clog2(TMO_CYC+1), timeout counter width.

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  N_CH  level interrupt requests.
- CONT_EQL  in  1  external service counter reached terminal count.
- CC_MUX  out  SEL_W  index of the granted channel.
- USCITE  out  2  status code: 00 idle, 01 serving, 10 acknowledged, 11 error.
- ENABLE_COUNT  out  1  enables the external service counter.
- ACKOUT  out  1  one-cycle acknowledge pulse.
- ERR_FLAG  out  1  sticky timeout indicator.
- CLR_ERR  in  1  synchronous clear of ERR_FLAG.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync-safe deassert):
  - state = IDLE; CC_MUX = 0; USCITE = 00; ENABLE_COUNT = 0; ACKOUT = 0; ERR_FLAG = 0; tmo_cnt = 0.
  - last_grant = N_CH-1, so round-robin starts at channel 0.
  - Reset mid-service drops ENABLE_COUNT and ACKOUT immediately (asynchronous).
- States: IDLE, ARB, SERVE, ACK, TMO, DRAIN.
- IDLE:
  - Outputs at idle values.
  - |REQ → ARB on the next edge.
- ARB (1 cycle):
  - Pick index: RR_MODE=0 picks the lowest set bit. RR_MODE=1 picks the first set bit searching from last_grant+1, modulo N_CH.
  - Register CC_MUX = pick; tmo_cnt = 0.
  - If REQ is all-zero in this cycle → IDLE.
  - Otherwise → SERVE.
- SERVE:
  - ENABLE_COUNT = 1; USCITE = 01; tmo_cnt increments each cycle.
  - If REQ[CC_MUX] = 0 (spurious abort) → IDLE. No ACK; ENABLE_COUNT drops next cycle. Abort has top priority.
  - Else if CONT_EQL = 1 → ACK. CONT_EQL beats a simultaneous timeout.
  - Else if tmo_cnt == TMO_CYC-1 → TMO.
- ACK (1 cycle):
  - ACKOUT = 1; USCITE = 10; ENABLE_COUNT = 0; last_grant = CC_MUX.
  - → DRAIN.
- TMO (1 cycle):
  - USCITE = 11; ENABLE_COUNT = 0; ACKOUT = 0; ERR_FLAG set; last_grant = CC_MUX, so the faulty channel loses round-robin priority.
  - → DRAIN.
- DRAIN:
  - USCITE holds its last value (10 or 11); ENABLE_COUNT = 0.
  - Waits for REQ[CC_MUX] = 0.
  - Then → ARB if any other REQ bit is set, else → IDLE.
- Latency:
  - REQ rise to ENABLE_COUNT = 1 is 2 cycles (IDLE→ARB→SERVE).
  - CONT_EQL sampled to ACKOUT is 1 cycle.
- ERR_FLAG:
  - Set on entry to TMO.
  - Cleared by CLR_ERR = 1.
  - A simultaneous set and clear leaves the flag set.
- CONT_EQL is ignored in every state except SERVE.
- tmo_cnt saturates and never wraps.
- REQ bits that change in ARB are sampled in the ARB cycle only.

Decomposition:
- Package irq_multi_pkg:
  - State enum typedef.
  - USCITE code constants: US_IDLE, US_SERV, US_ACK, US_ERR.
- Sub-module irq_rr_pick: purely combinational.
  - Inputs: req[N_CH], last[SEL_W], rr_mode.
  - Outputs: idx[SEL_W], valid.
  - Implemented as a double-width masked priority encoder.
- The top holds the FSM, the timeout counter and the output registers.

Test Plan (N_CH=4, TMO_CYC=16):
- Basic service: RR_MODE=0; REQ=0100 at cycle 0 → ENABLE_COUNT=1 and CC_MUX=2 at cycle 2. CONT_EQL at cycle 5 → ACKOUT=1 and USCITE=10 at cycle 6, one cycle wide. Drop REQ → IDLE, USCITE=00.
- Priority vs round-robin, REQ held at 1011 with each service completing:
  - RR_MODE=0: grant sequence 0,0,0.
  - RR_MODE=1: grant sequence 0,1,3,0.
- Timeout: REQ=0001 with CONT_EQL never asserted → TMO at cycle 2+16. USCITE=11, ERR_FLAG=1, no ACKOUT. Then CLR_ERR → ERR_FLAG=0.
- Simultaneous events:
  - CONT_EQL on the final timeout cycle → ACK path taken; ERR_FLAG stays 0.
  - CLR_ERR together with timeout entry → ERR_FLAG=1.
- Spurious abort: REQ[1] deasserts during SERVE → ENABLE_COUNT=0 next cycle; USCITE=00; ACKOUT never 1.
- Reset mid-operation: RESET_N low during SERVE → ENABLE_COUNT=0 and state IDLE without waiting for a clock edge. After release, RR restarts at channel 0.
